fsmc_slave_scheduler: RTL and testbench
=======================================

Name: fsmc_slave_scheduler

Overview:
- Transaction controller between the FSMC interface's internal protocol (cs, addr_en, rd_en, wr_en, latched bus data) and up to NUM_SLAVES register-bank slaves.
- Latches each transaction's address and slave select, issues one-cycle write strobes, and runs a request/acknowledge read handshake with timeout.
- Returns read data, or a default word on timeout, to the interface's return-data input, and counts protocol errors.

Parameters:
- DATA_WIDTH, 16, width of address/data words.
- NUM_SLAVES, 4, number of slaves; equals the cs vector width.
- SEL_WIDTH, 2, index width; must equal $clog2(NUM_SLAVES).
- TIMEOUT_CYCLES, 8, maximum cycles s_rd_req is held waiting for s_rd_ack (≥1).
- DEFAULT_RDATA, 16'hDEAD, word returned on read timeout.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cs  in  NUM_SLAVES  one-hot slave select from the interface.
- addr_en  in  1  high while the address phase is active.
- rd_en  in  1  one-cycle pulse: host write data valid on bus_data.
- wr_en  in  1  level: host read in progress, return data required.
- bus_data  in  DATA_WIDTH  address/write data latched by the interface.
- bus_rdata  out  DATA_WIDTH  read return word; wired to every interface wr_data element.
- s_addr  out  DATA_WIDTH  latched transaction address.
- s_wdata  out  DATA_WIDTH  write data.
- s_wr  out  NUM_SLAVES  one-cycle write strobe, one-hot.
- s_rd_req  out  NUM_SLAVES  read request level, one-hot.
- s_rd_ack  in  NUM_SLAVES  per-slave read acknowledge.
- s_rd_data  in  NUM_SLAVES*DATA_WIDTH  flat read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle error pulse.
- err_cnt  out  8  saturating error count.

Behaviour:
- Reset values: all outputs 0 except bus_rdata = DEFAULT_RDATA. State = IDLE; internal addr_en history register = 0.
- Address capture: on an addr_en falling edge (registered previous value 1, current 0), sample cs and bus_data in that cycle.
  - If cs is exactly one-hot: s_addr <= bus_data, sel <= index of the set bit, go to ADDR.
  - Otherwise (zero or multi-hot): err pulse, stay in IDLE.
- An addr_en falling edge in any state aborts the current transaction:
  - s_rd_req cleared, no s_wr issued, no err.
  - The new address is captured as above.
- ADDR state, priority order:
  - rd_en=1: s_wdata <= bus_data; s_wr[sel] = 1 for exactly the next cycle; go to IDLE. Write latency is 1 cycle from rd_en.
  - wr_en=1: go to READ_REQ; s_rd_req[sel] = 1 from the next cycle; timer = 0.
  - cs == 0 (no strobe): go to IDLE silently.
  - rd_en is checked before cs == 0, because the interface clears cs in the same cycle as the rd_en pulse.
- READ_REQ:
  - While s_rd_req[sel] is high, increment the timer each cycle.
  - s_rd_ack[sel]=1: bus_rdata <= s_rd_data slice sel; clear s_rd_req; go to READ_HOLD. An ack in the first request cycle is legal.
  - Acks from unselected slaves are ignored.
  - Timer reaches TIMEOUT_CYCLES without ack: bus_rdata <= DEFAULT_RDATA, err pulse, clear s_rd_req, go to READ_HOLD.
  - wr_en falls before ack or timeout: clear s_rd_req, err pulse, go to IDLE.
- READ_HOLD: bus_rdata is held stable; when wr_en = 0, go to IDLE. bus_rdata keeps its last value in IDLE.
- err_cnt: increments on every err pulse and saturates at 255.
- Invariant: s_wr and s_rd_req are never both nonzero, and each is at most one-hot.
- Reset mid-operation: outputs return to reset values asynchronously; no strobe or request may glitch out.

Test Plan:
- cs=4'b0010, addr_en falls with bus_data=16'h0123, then rd_en pulse with bus_data=16'hBEEF (cs cleared same cycle) -> next cycle s_wr=4'b0010 for one cycle, s_addr=16'h0123, s_wdata=16'hBEEF, err=0.
- cs=4'b0100, addr 16'h0010, wr_en rises, slave 2 acks 3 cycles after request with data 16'h5A5A -> s_rd_req=4'b0100 for exactly 3 cycles, then bus_rdata=16'h5A5A held until wr_en falls, then busy=0.
- Read to slave 1 with no ack, TIMEOUT_CYCLES=8 -> s_rd_req high for 8 cycles, bus_rdata=16'hDEAD, one err pulse, err_cnt 0->1.
- Addr_en falling edge with cs=4'b0000, then with cs=4'b0011 -> two err pulses, state stays IDLE, s_wr and s_rd_req stay 0.
- During READ_REQ to slave 3, a new addr_en falling edge with cs=4'b0001 -> s_rd_req drops the next cycle, s_addr updates, no err; a following rd_en pulse gives s_wr=4'b0001.
- Force 300 errors -> err_cnt saturates at 8'hFF. Assert reset_n mid-read -> s_rd_req=0 immediately, bus_rdata=16'hDEAD.

Source files
------------

// File: rtl/fsmc_slave_scheduler_if.sv
// Bus bundle between the FSMC protocol front end and the slave scheduler.
// slave: scheduler side (host strobes and slave returns in); master: driver side.
interface fsmc_slave_scheduler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SLAVES = 4
);
    logic [NUM_SLAVES-1:0]            cs;
    logic                             addr_en;
    logic                             rd_en;
    logic                             wr_en;
    logic [DATA_WIDTH-1:0]            bus_data;
    logic [DATA_WIDTH-1:0]            bus_rdata;
    logic [DATA_WIDTH-1:0]            s_addr;
    logic [DATA_WIDTH-1:0]            s_wdata;
    logic [NUM_SLAVES-1:0]            s_wr;
    logic [NUM_SLAVES-1:0]            s_rd_req;
    logic [NUM_SLAVES-1:0]            s_rd_ack;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rd_data;
    logic                             busy;
    logic                             err;
    logic [7:0]                       err_cnt;

    modport slave (
        input  cs, addr_en, rd_en, wr_en, bus_data, s_rd_ack, s_rd_data,
        output bus_rdata, s_addr, s_wdata, s_wr, s_rd_req, busy, err, err_cnt
    );

    modport master (
        output cs, addr_en, rd_en, wr_en, bus_data, s_rd_ack, s_rd_data,
        input  bus_rdata, s_addr, s_wdata, s_wr, s_rd_req, busy, err, err_cnt
    );
endinterface

// File: rtl/fsmc_slave_scheduler.sv
// Transaction scheduler: FSMC strobes -> one-hot slave writes / read handshake.
// Ports: clk, reset_n (async, active low), bus (slave modport: cs/addr_en/rd_en/
// wr_en/bus_data in, s_* slave side, bus_rdata return, busy/err/err_cnt status).
module fsmc_slave_scheduler #(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    NUM_SLAVES     = 4,
    parameter int                    SEL_WIDTH      = 2,
    parameter int                    TIMEOUT_CYCLES = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA  = 16'hDEAD
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fsmc_slave_scheduler_if.slave bus
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ADDR      = 2'd1;
    localparam logic [1:0] READ_REQ  = 2'd2;
    localparam logic [1:0] READ_HOLD = 2'd3;
    localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            state_q, state_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d, cs_idx;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_SLAVES-1:0] wr_q, wr_d;
    logic [NUM_SLAVES-1:0] req_q, req_d;
    logic [NUM_SLAVES-1:0] sel_mask;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  err_q, err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  addr_en_q;
    logic                  addr_fall;
    logic                  cs_onehot;

    assign addr_fall = addr_en_q && !bus.addr_en;
    assign cs_onehot = ($countones(bus.cs) == 1);
    assign sel_mask  = NUM_SLAVES'(1) << sel_q;

    always_comb begin
        cs_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (bus.cs[i]) cs_idx = SEL_WIDTH'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = '0;
        req_d   = req_q;
        timer_d = timer_q;
        err_d   = 1'b0;
        // A new address phase always wins and silently drops the old transaction.
        if (addr_fall) begin
            req_d = '0;
            if (cs_onehot) begin
                addr_d  = bus.bus_data;
                sel_d   = cs_idx;
                state_d = ADDR;
            end else begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                ADDR: begin
                    // rd_en first: the front end drops cs together with rd_en.
                    if (bus.rd_en) begin
                        wdata_d = bus.bus_data;
                        wr_d    = sel_mask;
                        state_d = IDLE;
                    end else if (bus.wr_en) begin
                        req_d   = sel_mask;
                        timer_d = '0;
                        state_d = READ_REQ;
                    end else if (bus.cs == '0) begin
                        state_d = IDLE;
                    end
                end
                READ_REQ: begin
                    timer_d = timer_q + TW'(1);
                    if (bus.s_rd_ack[sel_q]) begin
                        rdata_d = bus.s_rd_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
                        req_d   = '0;
                        state_d = READ_HOLD;
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        rdata_d = DEFAULT_RDATA;
                        err_d   = 1'b1;
                        req_d   = '0;
                        state_d = READ_HOLD;
                    end else if (!bus.wr_en) begin
                        err_d   = 1'b1;
                        req_d   = '0;
                        state_d = IDLE;
                    end
                end
                READ_HOLD: begin
                    if (!bus.wr_en) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= DEFAULT_RDATA;
            wr_q      <= '0;
            req_q     <= '0;
            timer_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            addr_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wr_q      <= wr_d;
            req_q     <= req_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            addr_en_q <= bus.addr_en;
        end
    end

    assign bus.s_addr    = addr_q;
    assign bus.s_wdata   = wdata_q;
    assign bus.bus_rdata = rdata_q;
    assign bus.s_wr      = wr_q;
    assign bus.s_rd_req  = req_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_fsmc_slave_scheduler.sv
// Directed + randomized bench for fsmc_slave_scheduler.
// Expected values come from a transaction-level model of the scheduler rules.
module tb_fsmc_slave_scheduler;
    localparam int          DW  = 16;
    localparam int          NS  = 4;
    localparam int          T   = 8;
    localparam logic [15:0] DEF = 16'hDEAD;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   total   = 0;
    int   bad     = 0;
    int   model_err = 0;

    fsmc_slave_scheduler_if #(.DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

    fsmc_slave_scheduler #(
        .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SEL_WIDTH(2),
        .TIMEOUT_CYCLES(T), .DEFAULT_RDATA(DEF)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_cnt();
        return (model_err > 255) ? 8'hFF : 8'(model_err);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        chk("invariant", {29'd0,
            (bus.s_wr != 0) && (bus.s_rd_req != 0),
            $countones(bus.s_wr) > 1,
            $countones(bus.s_rd_req) > 1}, 32'd0);
    endtask

    task automatic addr_phase(input logic [3:0] c, input logic [15:0] a);
        bus.cs = c;
        bus.addr_en = 1'b1;
        bus.bus_data = a;
        tick();
        bus.addr_en = 1'b0;
        tick();
    endtask

    task automatic do_write(input int slv, input logic [15:0] a,
                            input logic [15:0] d);
        logic [3:0] m;
        m = 4'(1 << slv);
        addr_phase(m, a);
        chk("w_addr", bus.s_addr, a);
        chk("w_busy", bus.busy, 1);
        bus.cs = 4'd0;
        bus.rd_en = 1'b1;
        bus.bus_data = d;
        tick();
        chk("w_strobe", bus.s_wr, m);
        chk("w_wdata", bus.s_wdata, d);
        chk("w_addr2", bus.s_addr, a);
        chk("w_err", bus.err, 0);
        bus.rd_en = 1'b0;
        tick();
        chk("w_strobe_end", bus.s_wr, 0);
        chk("w_idle", bus.busy, 0);
    endtask

    // k = cycle of the request on which the slave acks (0 = never).
    task automatic do_read(input int slv, input logic [15:0] a, input int k,
                           input logic [15:0] d);
        logic [3:0]  m;
        logic [63:0] rd;
        int          n;
        bit          to;
        m = 4'(1 << slv);
        addr_phase(m, a);
        chk("r_addr", bus.s_addr, a);
        bus.wr_en = 1'b1;
        tick();
        n = 0;
        while (bus.s_rd_req != 0 && n < 40) begin
            chk("r_req", bus.s_rd_req, m);
            n++;
            bus.s_rd_ack = 4'($urandom) & ~m;
            rd = {$urandom, $urandom};
            if (n == k) begin
                bus.s_rd_ack = bus.s_rd_ack | m;
                rd[slv*16 +: 16] = d;
            end
            bus.s_rd_data = rd;
            tick();
        end
        bus.s_rd_ack = 4'd0;
        to = (k == 0 || k > T);
        if (to) model_err++;
        chk("r_cycles", n, to ? T : k);
        chk("r_rdata", bus.bus_rdata, to ? DEF : d);
        chk("r_err", bus.err, to);
        chk("r_errcnt", bus.err_cnt, exp_cnt());
        chk("r_hold_busy", bus.busy, 1);
        repeat (2) begin
            tick();
            chk("r_hold", bus.bus_rdata, to ? DEF : d);
            chk("r_hold_err", bus.err, 0);
            chk("r_hold_busy", bus.busy, 1);
        end
        bus.wr_en = 1'b0;
        bus.cs = 4'd0;
        tick();
        chk("r_idle", bus.busy, 0);
        chk("r_keep", bus.bus_rdata, to ? DEF : d);
    endtask

    task automatic bad_cs(input logic [3:0] c);
        addr_phase(c, 16'($urandom));
        model_err++;
        chk("b_err", bus.err, 1);
        chk("b_idle", bus.busy, 0);
        chk("b_wr", bus.s_wr, 0);
        chk("b_req", bus.s_rd_req, 0);
        chk("b_cnt", bus.err_cnt, exp_cnt());
    endtask

    initial begin
        logic [3:0] c;
        int         kind;
        bus.cs = '0;
        bus.addr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.bus_data = '0;
        bus.s_rd_ack = '0;
        bus.s_rd_data = '0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", bus.bus_rdata, DEF);
        chk("rst_wr", bus.s_wr, 0);
        chk("rst_req", bus.s_rd_req, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_cnt", bus.err_cnt, 0);
        chk("rst_addr", bus.s_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;

        do_write(1, 16'h0123, 16'hBEEF);
        do_read(2, 16'h0010, 3, 16'h5A5A);
        do_read(1, 16'h0020, 0, 16'h0000);
        do_read(0, 16'h0030, 1, 16'h1111);
        do_read(3, 16'h0040, T, 16'h2222);
        bad_cs(4'b0000);
        bad_cs(4'b0011);

        // Abort a read to slave 3 with a fresh address phase.
        addr_phase(4'b1000, 16'h0300);
        bus.wr_en = 1'b1;
        tick();
        tick();
        chk("ab_req", bus.s_rd_req, 4'b1000);
        bus.addr_en = 1'b1;
        bus.cs = 4'b0001;
        bus.bus_data = 16'h0044;
        tick();
        chk("ab_req_held", bus.s_rd_req, 4'b1000);
        bus.addr_en = 1'b0;
        tick();
        chk("ab_req_drop", bus.s_rd_req, 0);
        chk("ab_addr", bus.s_addr, 16'h0044);
        chk("ab_err", bus.err, 0);
        chk("ab_cnt", bus.err_cnt, exp_cnt());
        bus.wr_en = 1'b0;
        bus.cs = 4'd0;
        bus.rd_en = 1'b1;
        bus.bus_data = 16'h7777;
        tick();
        chk("ab_wr", bus.s_wr, 4'b0001);
        chk("ab_wdata", bus.s_wdata, 16'h7777);
        bus.rd_en = 1'b0;
        tick();
        chk("ab_idle", bus.busy, 0);

        // ADDR with cs withdrawn and no strobe returns quietly.
        addr_phase(4'b0100, 16'h0055);
        chk("q_busy", bus.busy, 1);
        bus.cs = 4'd0;
        tick();
        chk("q_idle", bus.busy, 0);
        chk("q_err", bus.err, 0);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                do_write($urandom_range(0, 3), 16'($urandom), 16'($urandom));
            end else if (kind == 1) begin
                do_read($urandom_range(0, 3), 16'($urandom),
                        $urandom_range(0, 10), 16'($urandom));
            end else if (kind == 2) begin
                do c = 4'($urandom); while ($countones(c) == 1);
                bad_cs(c);
            end else begin
                do_read($urandom_range(0, 3), 16'($urandom),
                        $urandom_range(1, 3), 16'($urandom));
            end
        end

        for (int i = 0; i < 300; i++) bad_cs(4'b0000);
        chk("sat_cnt", bus.err_cnt, 8'hFF);

        // Reset in the middle of a read request.
        do_read(2, 16'h0066, 2, 16'h1234);
        addr_phase(4'b0010, 16'h0077);
        bus.wr_en = 1'b1;
        tick();
        tick();
        chk("mr_req", bus.s_rd_req, 4'b0010);
        #2 reset_n = 1'b0;
        #1;
        model_err = 0;
        chk("mr_req0", bus.s_rd_req, 0);
        chk("mr_rdata", bus.bus_rdata, DEF);
        chk("mr_cnt", bus.err_cnt, exp_cnt());
        chk("mr_busy", bus.busy, 0);
        bus.wr_en = 1'b0;
        bus.cs = 4'd0;
        @(negedge clk);
        reset_n = 1'b1;
        do_write(3, 16'h0088, 16'h4321);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
